edge_event_arbiter: RTL and testbench

//   Shares one event consumer among N_CH asynchronous level inputs (keys, external strobes).

---
 rtl/edge_arb_pkg.sv | 10 +
 rtl/edge_chan.sv | 46 ++++
 rtl/edge_event_arbiter.sv | 100 ++++++++++
 tb/tb_edge_event_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge event arbiter.
package edge_arb_pkg;
  localparam int N_CH_DEF = 4;
  localparam int ID_W_DEF = $clog2(N_CH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;
endpackage

// File: rtl/edge_chan.sv
// One input channel: 2-FF synchroniser, rising-edge detect, pending flag.
// With EVT_OVERRUN_EN defined, also keeps a sticky overrun flag.
module edge_chan (
  input  logic clk,
  input  logic rst,
  input  logic i_data_in,
  input  logic i_clr,
`ifdef EVT_OVERRUN_EN
  input  logic i_ovr_clr,
  output logic o_overrun,
`endif
  output logic o_pending,
  output logic o_edge
);
  logic s1_q, s2_q, h_q, pend_q, pend_d;

  assign o_edge    = s2_q & ~h_q;
  // A new edge beats a clear in the same cycle, so the event is not lost.
  assign pend_d    = o_edge | (pend_q & ~i_clr);
  assign o_pending = pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      h_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      s1_q   <= i_data_in;
      s2_q   <= s1_q;
      h_q    <= s2_q;
      pend_q <= pend_d;
    end
  end

`ifdef EVT_OVERRUN_EN
  logic ovr_q, ovr_d;
  assign ovr_d     = i_ovr_clr ? 1'b0 : (ovr_q | (o_edge & pend_q & ~i_clr));
  assign o_overrun = ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovr_q <= 1'b0;
    else      ovr_q <= ovr_d;
  end
`endif
endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter offering pending edge events as channel IDs on valid/ready.
// Optional overrun tracking is enabled by defining EVT_OVERRUN_EN.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_data_in,
  output logic            o_evt_valid,
  input  logic            i_evt_ready,
  output logic [ID_W-1:0] o_evt_id,
  output logic [N_CH-1:0] o_pending,
`ifdef EVT_OVERRUN_EN
  input  logic            i_ovr_clr,
  output logic [N_CH-1:0] o_overrun,
`endif
  output logic            o_busy
);
  logic [N_CH-1:0] pend, edg, clr;
  arb_state_e      state_q;
  logic            valid_q;
  logic [ID_W-1:0] id_q, ptr_q;
  logic            win_found;
  logic [ID_W-1:0] win_id, cand;
  int              idx;
  logic            unused_edges;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_data_in (i_data_in[g]),
      .i_clr     (clr[g]),
`ifdef EVT_OVERRUN_EN
      .i_ovr_clr (i_ovr_clr),
      .o_overrun (o_overrun[g]),
`endif
      .o_pending (pend[g]),
      .o_edge    (edg[g])
    );
  end

  assign unused_edges = ^edg;

  always_comb begin
    clr = '0;
    if (state_q == OFFER && valid_q && i_evt_ready) clr[id_q] = 1'b1;
  end

  // Walk downward in offset so the lowest offset from ptr wins last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = ID_W'(idx);
      if (pend[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            id_q    <= win_id;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (i_evt_ready) begin
            valid_q <= 1'b0;
            ptr_q   <= (id_q == ID_W'(N_CH - 1)) ? '0 : id_q + 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_id    = id_q;
  assign o_pending   = pend;
  assign o_busy      = (|pend) | valid_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: vector table plus directed corner sequences.
module tb_edge_event_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       ready;
  logic       valid;
  logic [1:0] id;
  logic [3:0] pending;
  logic       busy;
`ifdef EVT_OVERRUN_EN
  logic       ovr_clr;
  logic [3:0] overrun;
`endif

  edge_event_arbiter #(.N_CH(4), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data_in   (data_in),
    .o_evt_valid (valid),
    .i_evt_ready (ready),
    .o_evt_id    (id),
    .o_pending   (pending),
`ifdef EVT_OVERRUN_EN
    .i_ovr_clr   (ovr_clr),
    .o_overrun   (overrun),
`endif
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      edges;
    logic [2:0]      n;
    logic [3:0][1:0] ids;
  } vec_t;

  vec_t vt [6];
  int   q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   burst = 0;
  int   mon_burst = -1;
  bit   gap_chk = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((q.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", int'(q.size() != 0 || busy), 0);
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("valid_timeout", int'(valid), 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted event must match the next expected ID.
  always @(negedge clk) begin
    if (rst && valid && ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_evt: got id %0d expected none", id);
      end else begin
        int e;
        e = q.pop_front();
        chk("evt_id", int'(id), e);
      end
      if (gap_chk && mon_burst == burst) chk("evt_gap", cyc - last_hs, 2);
      mon_burst = burst;
      last_hs   = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    vt[0] = '{edges: 4'b1000, n: 3'd1, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
    vt[1] = '{edges: 4'b1111, n: 3'd4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
    vt[2] = '{edges: 4'b0110, n: 3'd2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
    vt[3] = '{edges: 4'b1001, n: 3'd2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
    vt[4] = '{edges: 4'b0101, n: 3'd2, ids: {2'd0, 2'd0, 2'd0, 2'd2}};
    vt[5] = '{edges: 4'b1011, n: 3'd3, ids: {2'd0, 2'd0, 2'd3, 2'd1}};

    rst = 1'b0; data_in = '0; ready = 1'b0;
`ifdef EVT_OVERRUN_EN
    ovr_clr = 1'b0;
`endif

    // Reset with toggling inputs, then release with ch2 held high.
    repeat (4) begin
      step();
      data_in = 4'($urandom);
      @(negedge clk);
      chk("reset_outs", int'({valid, id, pending, busy}), 0);
`ifdef EVT_OVERRUN_EN
      chk("reset_ovr", int'(overrun), 0);
`endif
    end
    data_in = 4'b0100;
    ready = 1'b1;
    burst++;
    q.push_back(2);
    step();
    rst = 1'b1;
    drain(40);
    repeat (8) step();
    data_in = '0;
    repeat (4) step();

    // Single edge on ch1: latency and one-cycle pulse.
    burst++;
    q.push_back(1);
    step();
    data_in[1] = 1'b1;
    lat = 0;
    while (!valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("single_id", int'(id), 1);
    @(negedge clk);
    chk("pulse_end", int'({valid, pending[1]}), 0);
    data_in = '0;
    repeat (4) step();

    // Vector table: simultaneous edges, round-robin order, 2-clock spacing.
    for (int i = 0; i < 6; i++) begin
      burst++;
      gap_chk = 1'b1;
      for (int j = 0; j < int'(vt[i].n); j++) q.push_back(int'(vt[i].ids[j]));
      step();
      data_in = vt[i].edges;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("vec_pending", int'(pending), int'(vt[i].edges));
      drain(60);
      step();
      data_in = '0;
      repeat (4) step();
      gap_chk = 1'b0;
    end

    // Backpressure: ch3 held while ch0 arrives; ch0 served next.
    ready = 1'b0;
    burst++;
    q.push_back(3);
    q.push_back(0);
    step();
    data_in[3] = 1'b1;
    wait_valid(20);
    chk("bp_first_id", int'(id), 3);
    step();
    data_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", int'({valid, id}), 7);
    end
    chk("bp_pending", int'(pending), 4'b1001);
    chk("bp_busy", int'(busy), 1);
    step();
    ready = 1'b1;
    drain(40);
    data_in = '0;
    repeat (4) step();

    // Move ptr to 3 with a lone ch2 event.
    burst++;
    q.push_back(2);
    step();
    data_in = 4'b0100;
    drain(40);
    data_in = '0;
    repeat (4) step();

    // Wrap plus set/clear collision on ch3.
    ready = 1'b0;
    burst++;
    q.push_back(3);
    step();
    data_in[3] = 1'b1;
    wait_valid(20);
    chk("col_first_id", int'(id), 3);
    step();
    data_in = 4'b0011;
    repeat (4) step();
    data_in[3] = 1'b1;
    step();
    step();
    q.push_back(0);
    q.push_back(1);
    q.push_back(3);
    ready = 1'b1;
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("col_pending", int'(pending), 4'b1011);
    chk("col_bubble", int'(valid), 0);
    step();
    ready = 1'b1;
    drain(60);
    data_in = '0;
    repeat (4) step();

`ifdef EVT_OVERRUN_EN
    // Two ch1 edges before accept: overrun, single event, then clear.
    ready = 1'b0;
    burst++;
    q.push_back(1);
    step();
    data_in[1] = 1'b1;
    repeat (4) step();
    data_in[1] = 1'b0;
    repeat (4) step();
    data_in[1] = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("ovr_set", int'(overrun), 4'b0010);
    chk("ovr_offer", int'({valid, id}), 5);
    step();
    ready = 1'b1;
    drain(40);
    chk("ovr_sticky", int'(overrun), 4'b0010);
    step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", int'(overrun), 0);
    data_in = '0;
    repeat (4) step();
`endif

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
